// File: rtl/ofifo_pkg.sv
// Shared defaults for the output-side psum collector.
// PTR_W carries one extra wrap bit above the storage index.
package ofifo_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 64;
  localparam int PTR_W   = $clog2(DEPTH) + 1;

  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/ofifo_col.sv
// Single-column FWFT FIFO with wrap-bit pointers; a full column still accepts
// a write when the same edge pops, because the slot being written is being freed.
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               pop,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               dropped
);

  localparam int ptr_w  = ptr_width(depth);
  localparam int addr_w = ptr_w - 1;

  logic [psum_bw-1:0] mem [depth];
  logic [ptr_w-1:0]   wptr_reg;
  logic [ptr_w-1:0]   rptr_reg;
  logic               accept;
  logic               do_pop;

  assign empty   = (wptr_reg == rptr_reg);
  assign full    = (wptr_reg[addr_w-1:0] == rptr_reg[addr_w-1:0]) &&
                   (wptr_reg[addr_w] != rptr_reg[addr_w]);
  assign do_pop  = pop && !empty;
  assign accept  = wr && (!full || do_pop);
  assign dropped = wr && full && !do_pop;
  assign dout    = mem[rptr_reg[addr_w-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (accept) wptr_reg <= wptr_reg + ptr_w'(1);
      if (do_pop) rptr_reg <= rptr_reg + ptr_w'(1);
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr_reg[addr_w-1:0]] <= din;
  end

endmodule

// File: rtl/ofifo_collector.sv
// Collects skewed per-column psums from the array's south edge and releases
// them as aligned rows once every column holds at least one entry.
module ofifo_collector
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   overflow,
  output logic                   underflow
);

  logic [col-1:0]         empty_vec;
  logic [col-1:0]         full_vec;
  logic [col-1:0]         dropped_vec;
  logic [psum_bw*col-1:0] head_row;
  logic [psum_bw*col-1:0] hold_reg;
  logic                   overflow_reg;
  logic                   underflow_reg;
  logic                   pop;

  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_col
      ofifo_col #(
        .psum_bw (psum_bw),
        .depth   (depth)
      ) u_col (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr[gi]),
        .pop     (pop),
        .din     (in[psum_bw*gi +: psum_bw]),
        .dout    (head_row[psum_bw*gi +: psum_bw]),
        .empty   (empty_vec[gi]),
        .full    (full_vec[gi]),
        .dropped (dropped_vec[gi])
      );
    end
  endgenerate

  assign o_valid   = &(~empty_vec);
  assign o_empty   = &empty_vec;
  assign o_full    = |full_vec;
  assign pop       = rd && o_valid;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  // When no full row is available, keep showing the last row presented.
  assign out = o_valid ? head_row : hold_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (o_valid)          hold_reg      <= head_row;
      if (|dropped_vec)     overflow_reg  <= 1'b1;
      if (rd && !o_valid)   underflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofifo_collector.sv
// Scoreboard bench: accepted writes are queued per column, popped rows and
// flags are compared against the queue heads after every clock edge.
module tb_ofifo_collector;

  localparam int NC = 8;
  localparam int BW = 16;
  localparam int DP = 64;

  logic             clk;
  logic             reset;
  logic [NC*BW-1:0] in_d;
  logic [NC-1:0]    wr;
  logic             rd;
  logic [NC*BW-1:0] out_d;
  logic             o_valid, o_full, o_empty, overflow, underflow;

  ofifo_collector #(.col(NC), .psum_bw(BW), .depth(DP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_d),
    .wr        (wr),
    .rd        (rd),
    .out       (out_d),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [BW-1:0]    mq [NC][$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  logic [NC*BW-1:0] m_last = '0;

  task automatic check_val(input string tag, input logic [NC*BW-1:0] obs,
                           input logic [NC*BW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*BW-1:0] mk(input int r);
    logic [NC*BW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*BW +: BW] = 16'(r*8 + c);
    return v;
  endfunction

  function automatic bit m_valid();
    for (int c = 0; c < NC; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NC*BW-1:0] m_head();
    logic [NC*BW-1:0] v = '0;
    for (int c = 0; c < NC; c++) if (mq[c].size() != 0) v[c*BW +: BW] = mq[c][0];
    return v;
  endfunction

  task automatic check_state();
    bit mv, me, mf;
    mv = m_valid();
    me = 1'b1;
    mf = 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (mq[c].size() != 0)  me = 1'b0;
      if (mq[c].size() >= DP) mf = 1'b1;
    end
    if (mv) m_last = m_head();
    check_val("o_valid", o_valid, mv);
    check_val("o_empty", o_empty, me);
    check_val("o_full", o_full, mf);
    check_val("overflow", overflow, m_ovf);
    check_val("underflow", underflow, m_unf);
    check_val("out", out_d, m_last);
  endtask

  task automatic cycle(input logic [NC-1:0] w, input logic [NC*BW-1:0] d, input logic r);
    bit mv, p;
    wr   = w;
    in_d = d;
    rd   = r;
    mv   = m_valid();
    p    = r && mv;
    if (p) begin
      $display("pop %0d out=%h", pops, out_d);
      check_val("pop_data", out_d, m_head());
      pops++;
    end
    for (int c = 0; c < NC; c++) begin
      if (w[c]) begin
        if (mq[c].size() < DP || p) mq[c].push_back(d[c*BW +: BW]);
        else m_ovf = 1'b1;
      end
    end
    if (r && !mv) m_unf = 1'b1;
    if (p) for (int c = 0; c < NC; c++) void'(mq[c].pop_front());
    @(posedge clk);
    #1;
    wr = '0;
    rd = 1'b0;
    check_state();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [NC*BW-1:0] d;
    int p0;
    reset = 1'b0;
    in_d  = '0;
    wr    = '0;
    rd    = 1'b0;
    #1;
    check_val("rst_empty", o_empty, 1'b1);
    check_val("rst_valid", o_valid, 1'b0);
    check_val("rst_out", out_d, '0);
    release_reset();

    // skewed fill: column c lands c cycles after column 0
    for (int c = 0; c < NC; c++) begin
      d = '0;
      d[c*BW +: BW] = 16'h0100 + 16'(c);
      cycle(NC'(1) << c, d, 1'b0);
      if (c == NC-2) check_val("skew_not_yet", o_valid, 1'b0);
    end
    for (int c = 0; c < NC; c++) d[c*BW +: BW] = 16'h0100 + 16'(c);
    check_val("skew_valid", o_valid, 1'b1);
    check_val("skew_out", out_d, d);
    cycle('0, '0, 1'b1);
    check_val("skew_drained", o_empty, 1'b1);

    // streaming with wrap
    p0 = pops;
    cycle('1, mk(0), 1'b0);
    for (int r = 1; r < 200; r++) begin
      cycle('1, mk(r), 1'b1);
      check_val("stream_nogap", o_valid, 1'b1);
    end
    cycle('0, '0, 1'b1);
    check_val("stream_count", 32'(pops - p0), 32'd200);
    check_val("stream_empty", o_empty, 1'b1);
    check_val("stream_flags", {overflow, underflow}, 2'b00);

    // column 0 fills alone, then one extra write is dropped
    for (int k = 0; k < DP; k++) cycle(8'h01, mk(500 + k), 1'b0);
    check_val("col0_full", o_full, 1'b1);
    check_val("col0_no_ovf", overflow, 1'b0);
    cycle(8'h01, mk(999), 1'b0);
    check_val("col0_ovf", overflow, 1'b1);
    check_val("col0_still_full", o_full, 1'b1);

    // asynchronous reset mid-stream, checked before any clock edge
    wr = 8'h03;
    #3;
    reset = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) mq[c].delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_last = '0;
    check_val("arst_empty", o_empty, 1'b1);
    check_val("arst_valid", o_valid, 1'b0);
    check_val("arst_full", o_full, 1'b0);
    check_val("arst_out", out_d, '0);
    check_val("arst_flags", {overflow, underflow}, 2'b00);
    wr = '0;
    release_reset();

    // every column full; write with simultaneous pop is accepted
    for (int k = 0; k < DP; k++) cycle('1, mk(1000 + k), 1'b0);
    check_val("all_full", o_full, 1'b1);
    cycle('1, mk(2000), 1'b1);
    check_val("full_pop_ovf", overflow, 1'b0);
    check_val("full_pop_full", o_full, 1'b1);
    for (int k = 0; k < DP; k++) cycle('0, '0, 1'b1);
    check_val("full_drained", o_empty, 1'b1);

    // underflow, then a full row still flows through
    cycle('0, '0, 1'b1);
    check_val("unf_set", underflow, 1'b1);
    cycle('1, mk(3000), 1'b0);
    check_val("unf_row_valid", o_valid, 1'b1);
    check_val("unf_row_data", out_d, mk(3000));
    cycle('0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
